// File: rtl/hms_time_source_pkg.sv
// Shared definitions for the packed time word, used by the time source and the display side.
package hms_time_source_pkg;

  localparam int FIELD_W = 6;
  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 6;
  localparam int HR_LSB  = 12;
  localparam int SET_BIT = 18;

  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] HR_MAX  = 6'd23;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_SEC = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_HR  = 2'd3
  } state_t;

  // Increment a time field, wrapping to zero once it reaches its maximum.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] val,
                                                  input logic [FIELD_W-1:0] max);
    logic [FIELD_W-1:0] res;
    if (val >= max) begin
      res = {FIELD_W{1'b0}};
    end else begin
      res = val + FIELD_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/hms_time_source_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and a registered
// one-cycle pulse on each accepted press (releases produce nothing).
module hms_time_source_btn_debounce
  import hms_time_source_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          level_q_r;
  logic          press_r;

  // synchronize the raw button into the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // accept a new level only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r   <= {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // registered rising-edge pulse keeps press latency fixed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_q_r <= level_r;
      press_r   <= level_r & ~level_q_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/hms_time_source.sv
// Time-of-day source: runs hh:mm:ss from a prescaled 1 Hz tick and lets the user
// stop and set each field with two debounced buttons.
module hms_time_source
  import hms_time_source_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [18:0] num,
  output logic [1:0]  sel,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic               mode_press_s;
  logic               inc_press_s;
  state_t             state_r;
  state_t             state_nx_s;
  logic [FIELD_W-1:0] sec_r, min_r, hr_r;
  logic [FIELD_W-1:0] sec_nx_s, min_nx_s, hr_nx_s;
  logic [PW-1:0]      presc_r;
  logic [PW-1:0]      presc_nx_s;
  logic               tick_r;
  logic               tick_nx_s;
  logic               set_r;

  hms_time_source_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_press_s)
  );

  hms_time_source_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .press (inc_press_s)
  );

  // next-state: prescaler and carry chain in RUN, then mode/increment presses
  always_comb begin
    state_nx_s = state_r;
    sec_nx_s   = sec_r;
    min_nx_s   = min_r;
    hr_nx_s    = hr_r;
    presc_nx_s = {PW{1'b0}};
    tick_nx_s  = 1'b0;

    if (state_r == ST_RUN) begin
      if (presc_r == PRESC_LAST) begin
        tick_nx_s = 1'b1;
        if (sec_r == SEC_MAX) begin
          sec_nx_s = 6'd0;
          if (min_r == MIN_MAX) begin
            min_nx_s = 6'd0;
            hr_nx_s  = wrap_inc(hr_r, HR_MAX);
          end else begin
            min_nx_s = min_r + 6'd1;
          end
        end else begin
          sec_nx_s = sec_r + 6'd1;
        end
      end else begin
        presc_nx_s = presc_r + PW'(1);
      end
    end else begin
      presc_nx_s = {PW{1'b0}};
    end

    // a mode press always wins; a coincident increment is dropped
    if (mode_press_s) begin
      case (state_r)
        ST_RUN:     state_nx_s = ST_SET_HR;
        ST_SET_HR:  state_nx_s = ST_SET_MIN;
        ST_SET_MIN: state_nx_s = ST_SET_SEC;
        ST_SET_SEC: state_nx_s = ST_RUN;
        default:    state_nx_s = ST_RUN;
      endcase
    end else if (inc_press_s) begin
      case (state_r)
        ST_SET_SEC: sec_nx_s = wrap_inc(sec_r, SEC_MAX);
        ST_SET_MIN: min_nx_s = wrap_inc(min_r, MIN_MAX);
        ST_SET_HR:  hr_nx_s  = wrap_inc(hr_r, HR_MAX);
        default:    state_nx_s = state_r;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // state, time fields, prescaler and output flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
      sec_r   <= 6'd0;
      min_r   <= 6'd0;
      hr_r    <= 6'd0;
      presc_r <= {PW{1'b0}};
      tick_r  <= 1'b0;
      set_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      sec_r   <= sec_nx_s;
      min_r   <= min_nx_s;
      hr_r    <= hr_nx_s;
      presc_r <= presc_nx_s;
      tick_r  <= tick_nx_s;
      set_r   <= (state_nx_s != ST_RUN);
    end
  end

  assign num[SEC_LSB +: FIELD_W] = sec_r;
  assign num[MIN_LSB +: FIELD_W] = min_r;
  assign num[HR_LSB  +: FIELD_W] = hr_r;
  assign num[SET_BIT]            = set_r;
  assign sel                     = state_r;
  assign tick                    = tick_r;

endmodule

// File: tb/tb_hms_time_source.sv
// Self-checking bench for hms_time_source with a seconds-of-day reference model.
module tb_hms_time_source;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;
  localparam int L         = DB_CYCLES + 4;
  localparam int EVN       = 8192;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_inc  = 1'b0;
  logic [18:0] num;
  logic [1:0]  sel;
  logic        tick;

  // press events the model applies at a given edge number after reset
  bit ev_mode [EVN];
  bit ev_inc  [EVN];

  // model: edge count, seconds of day, cycles since RUN entry, menu position
  // (0 RUN, 1 hour, 2 minute, 3 second) and the expected tick
  int cyc;
  int tod;
  int runcnt;
  int pos;
  bit tick_m;

  int n_tests = 0;
  int n_fail  = 0;

  hms_time_source #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .num      (num),
    .sel      (sel),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc    <= 0;
      tod    <= 0;
      runcnt <= 0;
      pos    <= 0;
      tick_m <= 1'b0;
    end else begin : model_step
      int c, t, r, p, h, m, s;
      bit tk;
      c  = cyc + 1;
      t  = tod;
      r  = runcnt;
      p  = pos;
      tk = 1'b0;
      if (p == 0) begin
        r = r + 1;
        if (r == TICK_DIV) begin
          r  = 0;
          tk = 1'b1;
          t  = (t + 1) % 86400;
        end
      end else begin
        r = 0;
      end
      if (c < EVN && ev_mode[c]) begin
        p = (p + 1) % 4;
      end else if (c < EVN && ev_inc[c] && p != 0) begin
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        if (p == 1) h = (h + 1) % 24;
        else if (p == 2) m = (m + 1) % 60;
        else s = (s + 1) % 60;
        t = h * 3600 + m * 60 + s;
      end
      cyc    <= c;
      tod    <= t;
      runcnt <= r;
      pos    <= p;
      tick_m <= tk;
    end
  end

  function automatic logic [18:0] exp_num();
    return {(pos != 0), 6'(tod / 3600), 6'((tod / 60) % 60), 6'(tod % 60)};
  endfunction

  function automatic logic [1:0] exp_sel();
    return (pos == 0) ? 2'd0 : 2'(4 - pos);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance n cycles, comparing the DUT against the model at each falling edge
  task automatic nstep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("num",  32'(num),  32'(exp_num()));
      check("sel",  32'(sel),  32'(exp_sel()));
      check("tick", 32'(tick), 32'(tick_m));
    end
  endtask

  task automatic sched_mode();
    if (cyc + L < EVN) ev_mode[cyc + L] = 1'b1;
  endtask

  task automatic sched_inc();
    if (cyc + L < EVN) ev_inc[cyc + L] = 1'b1;
  endtask

  task automatic press(input bit m, input bit i);
    if (m) begin
      btn_mode = 1'b1;
      sched_mode();
    end
    if (i) begin
      btn_inc = 1'b1;
      sched_inc();
    end
    nstep(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    nstep(10);
  endtask

  task automatic press_n(input bit m, input int n);
    for (int k = 0; k < n; k++) press(m, !m);
  endtask

  // reset asserted between clock edges; outputs must clear without an edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_num",  32'(num),  32'd0);
    check("rst_sel",  32'(sel),  32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    for (int i = 0; i < EVN; i++) begin
      ev_mode[i] = 1'b0;
      ev_inc[i]  = 1'b0;
    end
    nstep(3);
    check("rst_hold_num", 32'(num), 32'd0);
    rst = 1'b1;
  endtask

  // mode press from SET_SEC; leaves the bench at the first tick, button still held
  task automatic enter_run();
    int k;
    btn_mode = 1'b1;
    sched_mode();
    k = 0;
    while (sel !== 2'd0 && k < 20) begin
      nstep(1);
      k++;
    end
    check("run_entry_latency", 32'(k), 32'(L));
    k = 0;
    do begin
      nstep(1);
      k++;
    end while (tick !== 1'b1 && k < 30);
    check("first_tick_delay", 32'(k), 32'(TICK_DIV));
  endtask

  initial begin
    int ticks;
    #2;
    do_reset();

    // 1: async reset from a running clock
    nstep(75);
    check("t1_pre_reset", 32'(num), 32'd7);
    do_reset();

    // 2: free run
    ticks = 0;
    for (int i = 0; i < 1250; i++) begin
      nstep(1);
      if (tick === 1'b1) ticks++;
    end
    check("t2_ticks", 32'(ticks), 32'd125);
    check("t2_num", 32'(num), 32'({1'b0, 6'd0, 6'd2, 6'd5}));

    // 3: set fields with wrap
    do_reset();
    press(1'b1, 1'b0);
    check("t3_sel_hr", 32'(sel), 32'd3);
    check("t3_setbit", 32'(num[18]), 32'd1);
    press_n(1'b0, 25);
    check("t3_hr", 32'(num[17:12]), 32'd1);
    press_n(1'b1, 2);
    check("t3_sel_sec", 32'(sel), 32'd1);
    press_n(1'b0, 61);
    check("t3_sec", 32'(num[5:0]), 32'd1);
    check("t3_min", 32'(num[11:6]), 32'd0);
    enter_run();
    check("t3_after_tick", 32'(num), 32'({1'b0, 6'd1, 6'd0, 6'd2}));
    btn_mode = 1'b0;
    nstep(10);

    // 4: midnight rollover
    do_reset();
    press(1'b1, 1'b0);
    press_n(1'b0, 23);
    press(1'b1, 1'b0);
    press_n(1'b0, 59);
    press(1'b1, 1'b0);
    press_n(1'b0, 58);
    check("t4_set", 32'(num), 32'({1'b1, 6'd23, 6'd59, 6'd58}));
    enter_run();
    check("t4_tick1", 32'(num), 32'({1'b0, 6'd23, 6'd59, 6'd59}));
    btn_mode = 1'b0;
    nstep(10);
    check("t4_rollover", 32'(num), 32'd0);

    // 5: bounce rejection in SET_SEC
    do_reset();
    press_n(1'b1, 3);
    check("t5_sel", 32'(sel), 32'd1);
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      nstep(2);
    end
    btn_inc = 1'b1;
    sched_inc();
    nstep(L - 1);
    check("t5_before_L", 32'(num[5:0]), 32'd0);
    nstep(1);
    check("t5_at_L", 32'(num[5:0]), 32'd1);
    nstep(10);
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      nstep(2);
    end
    btn_inc = 1'b0;
    nstep(20);
    check("t5_release", 32'(num[5:0]), 32'd1);

    // 6: simultaneous presses in SET_MIN
    do_reset();
    press_n(1'b1, 2);
    press_n(1'b0, 5);
    check("t6_min_pre", 32'(num[11:6]), 32'd5);
    press(1'b1, 1'b1);
    check("t6_sel", 32'(sel), 32'd1);
    check("t6_min", 32'(num[11:6]), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
